// File: rtl/map_index_to_display_mover.sv
// Converts a map tile index into that tile's centre pixel and walks the sprite there one pixel per step tick.
// Optional build macro MOVER_SNAP_EN: the position jumps straight to the target in CALC instead of stepping.
module map_index_to_display_mover #(
    parameter int ORIGIN_X   = 336,
    parameter int ORIGIN_Y   = 27,
    parameter int TILE_SHIFT = 4,
    parameter int CENTER_OFF = 7,
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_idx_x,
    input  logic [5:0]  req_idx_y,
    input  logic        step_en,
    output logic [10:0] display_pos_x,
    output logic [9:0]  display_pos_y,
    output logic        moving,
    output logic        done,
    output logic        err_oob
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        MOVE = 2'd2
    } state_t;

    localparam logic [10:0] HOME_X  = 11'(ORIGIN_X + CENTER_OFF);
    localparam logic [9:0]  HOME_Y  = 10'(ORIGIN_Y + CENTER_OFF);
    localparam logic [6:0]  MAP_W_I = 7'(MAP_W);
    localparam logic [5:0]  MAP_H_I = 6'(MAP_H);

    state_t      state, state_nxt;
    logic [6:0]  idx_x;
    logic [5:0]  idx_y;
    logic [10:0] pos_x, tgt_x, calc_x;
    logic [9:0]  pos_y, tgt_y, calc_y;
    logic        accept, in_range, at_tgt;

    assign accept   = req_valid && req_ready;
    assign in_range = (req_idx_x < MAP_W_I) && (req_idx_y < MAP_H_I);
    assign at_tgt   = (pos_x == tgt_x) && (pos_y == tgt_y);

    // Tile corner plus centre offset, evaluated from the index latched at accept.
    assign calc_x = 11'(ORIGIN_X) + (11'(idx_x) << TILE_SHIFT) + 11'(CENTER_OFF);
    assign calc_y = 10'(ORIGIN_Y) + (10'(idx_y) << TILE_SHIFT) + 10'(CENTER_OFF);

    assign display_pos_x = pos_x;
    assign display_pos_y = pos_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        moving    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept && in_range) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                moving    = 1'b1;
                state_nxt = MOVE;
            end
            MOVE: begin
                moving = 1'b1;
                if (at_tgt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x   <= HOME_X;
            pos_y   <= HOME_Y;
            tgt_x   <= HOME_X;
            tgt_y   <= HOME_Y;
            idx_x   <= '0;
            idx_y   <= '0;
            done    <= 1'b0;
            err_oob <= 1'b0;
        end else begin
            done    <= (state == MOVE) && at_tgt;
            err_oob <= accept && !in_range;
            if (accept && in_range) begin
                idx_x <= req_idx_x;
                idx_y <= req_idx_y;
            end
            if (state == CALC) begin
                tgt_x <= calc_x;
                tgt_y <= calc_y;
`ifdef MOVER_SNAP_EN
                pos_x <= calc_x;
                pos_y <= calc_y;
`endif
            end
            // Axes step independently so a move with both deltas non-zero runs diagonally.
            if (state == MOVE && !at_tgt && step_en) begin
                if (pos_x < tgt_x) begin
                    pos_x <= pos_x + 11'd1;
                end else if (pos_x > tgt_x) begin
                    pos_x <= pos_x - 11'd1;
                end
                if (pos_y < tgt_y) begin
                    pos_y <= pos_y + 10'd1;
                end else if (pos_y > tgt_y) begin
                    pos_y <= pos_y - 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_map_index_to_display_mover.sv
// Randomised bench for map_index_to_display_mover; expected positions come from the tile-centre formula
// and a closed-form per-axis walk (start moves min(k,|d|) pixels toward target after k step ticks).
module tb_map_index_to_display_mover;

    localparam int OX = 336;
    localparam int OY = 27;
    localparam int HOME_X = 343;
    localparam int HOME_Y = 34;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_idx_x = '0;
    logic [5:0]  req_idx_y = '0;
    logic        step_en = 1'b0;
    logic [10:0] display_pos_x;
    logic [9:0]  display_pos_y;
    logic        moving, done, err_oob;

    int n_cmp = 0;
    int n_err = 0;
    int mx = HOME_X;
    int my = HOME_Y;

    map_index_to_display_mover dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx_x(req_idx_x), .req_idx_y(req_idx_y),
        .step_en(step_en),
        .display_pos_x(display_pos_x), .display_pos_y(display_pos_y),
        .moving(moving), .done(done), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int walk(input int s, input int t, input int k);
        return (t >= s) ? s + imin(k, t - s) : s - imin(k, s - t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({display_pos_x, display_pos_y} !== {11'(HOME_X), 10'(HOME_Y)}) begin
            n_err++;
            $display("FAIL reset_pos: got (%0d,%0d) want (%0d,%0d)", display_pos_x, display_pos_y, HOME_X, HOME_Y);
        end
        n_cmp++;
        if ({req_ready, moving, done, err_oob} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_flags: got rdy/mov/done/err=%b want 1000", {req_ready, moving, done, err_oob});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({req_ready, moving, done, display_pos_x} !== {3'b100, 11'(HOME_X)}) begin
            n_err++;
            $display("FAIL post_reset_idle: got rdy/mov/done=%b x=%0d want 100 x=%0d", {req_ready, moving, done}, display_pos_x, HOME_X);
        end
        mx = HOME_X;
        my = HOME_Y;
    endtask

    task automatic test_move(input int ix, input int iy, input int pct, input int hold, input bit noise);
        int  ex, ey, sx, sy, d, steps;
        bit  at_t, fin;
        ex = OX + ix * 16 + 7;
        ey = OY + iy * 16 + 7;
        sx = mx;
        sy = my;
        req_idx_x = 7'(ix);
        req_idx_y = 6'(iy);
        req_valid = 1'b1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL move_accept_ready: got %b want 1", req_ready);
        end
        tick();
        req_valid = noise;
        req_idx_x = 7'($urandom_range(0, 39));
        req_idx_y = 6'($urandom_range(0, 29));
        step_en = 1'b1;
        n_cmp++;
        if ({req_ready, moving, done, err_oob, display_pos_x, display_pos_y} !== {4'b0100, 11'(sx), 10'(sy)}) begin
            n_err++;
            $display("FAIL move_calc: got rdy/mov/done/err=%b pos=(%0d,%0d) want 0100 pos=(%0d,%0d)",
                     {req_ready, moving, done, err_oob}, display_pos_x, display_pos_y, sx, sy);
        end
        tick();
`ifdef MOVER_SNAP_EN
        sx = ex;
        sy = ey;
`endif
        d = (iabs(ex - sx) > iabs(ey - sy)) ? iabs(ex - sx) : iabs(ey - sy);
        steps = 0;
        fin = 1'b0;
        for (int c = 0; c < LIMIT && !fin; c++) begin
            n_cmp++;
            if ({display_pos_x, display_pos_y, req_ready, moving, done} !==
                {11'(walk(sx, ex, steps)), 10'(walk(sy, ey, steps)), 3'b010}) begin
                n_err++;
                $display("FAIL move_step(%0d,%0d) k=%0d: got pos=(%0d,%0d) rdy/mov/done=%b want pos=(%0d,%0d) 010",
                         ix, iy, steps, display_pos_x, display_pos_y, {req_ready, moving, done},
                         walk(sx, ex, steps), walk(sy, ey, steps));
            end
            at_t = (steps == d);
            step_en = (c >= hold) && ($urandom_range(0, 99) < pct);
            req_valid = noise && ($urandom_range(0, 1) == 1);
            req_idx_x = 7'($urandom_range(0, 39));
            if (!at_t && step_en) steps++;
            tick();
            if (at_t) begin
                req_valid = 1'b0;
                step_en = 1'b0;
                fin = 1'b1;
                n_cmp++;
                if ({done, req_ready, moving, err_oob, display_pos_x, display_pos_y} !== {4'b1100, 11'(ex), 10'(ey)}) begin
                    n_err++;
                    $display("FAIL move_done(%0d,%0d): got done/rdy/mov/err=%b pos=(%0d,%0d) want 1100 pos=(%0d,%0d)",
                             ix, iy, {done, req_ready, moving, err_oob}, display_pos_x, display_pos_y, ex, ey);
                end
            end
        end
        if (!fin) begin
            n_err++;
            $display("FAIL move_timeout(%0d,%0d): got no arrival after %0d cycles want done", ix, iy, LIMIT);
        end
        mx = ex;
        my = ey;
        tick();
        n_cmp++;
        if ({done, req_ready, display_pos_x, display_pos_y} !== {2'b01, 11'(ex), 10'(ey)}) begin
            n_err++;
            $display("FAIL done_single_pulse: got done/rdy=%b pos=(%0d,%0d) want 01 pos=(%0d,%0d)",
                     {done, req_ready}, display_pos_x, display_pos_y, ex, ey);
        end
    endtask

    task automatic test_oob(input int ix, input int iy);
        req_idx_x = 7'(ix);
        req_idx_y = 6'(iy);
        req_valid = 1'b1;
        step_en = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if ({err_oob, req_ready, moving, done, display_pos_x, display_pos_y} !== {4'b1100, 11'(mx), 10'(my)}) begin
            n_err++;
            $display("FAIL oob(%0d,%0d): got err/rdy/mov/done=%b pos=(%0d,%0d) want 1100 pos=(%0d,%0d)",
                     ix, iy, {err_oob, req_ready, moving, done}, display_pos_x, display_pos_y, mx, my);
        end
        tick();
        step_en = 1'b0;
        n_cmp++;
        if ({err_oob, req_ready, moving, display_pos_x, display_pos_y} !== {3'b010, 11'(mx), 10'(my)}) begin
            n_err++;
            $display("FAIL oob_after(%0d,%0d): got err/rdy/mov=%b pos=(%0d,%0d) want 010 pos=(%0d,%0d)",
                     ix, iy, {err_oob, req_ready, moving}, display_pos_x, display_pos_y, mx, my);
        end
    endtask

    task automatic test_reset_mid_move(input int ix, input int iy, input int k);
        int ex, ey, sx, sy;
        ex = OX + ix * 16 + 7;
        ey = OY + iy * 16 + 7;
        sx = mx;
        sy = my;
        req_idx_x = 7'(ix);
        req_idx_y = 6'(iy);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
`ifndef MOVER_SNAP_EN
        tick();
        for (int c = 0; c < k; c++) begin
            n_cmp++;
            if ({display_pos_x, display_pos_y} !== {11'(walk(sx, ex, c)), 10'(walk(sy, ey, c))}) begin
                n_err++;
                $display("FAIL pre_reset_step k=%0d: got (%0d,%0d) want (%0d,%0d)",
                         c, display_pos_x, display_pos_y, walk(sx, ex, c), walk(sy, ey, c));
            end
            step_en = 1'b1;
            tick();
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step_en = 1'b0;
        n_cmp++;
        if ({display_pos_x, display_pos_y, req_ready, moving, done} !== {11'(HOME_X), 10'(HOME_Y), 3'b100}) begin
            n_err++;
            $display("FAIL reset_mid_move: got pos=(%0d,%0d) rdy/mov/done=%b want pos=(%0d,%0d) 100",
                     display_pos_x, display_pos_y, {req_ready, moving, done}, HOME_X, HOME_Y);
        end
        tick();
        n_cmp++;
        if ({done, moving, display_pos_x, display_pos_y} !== {2'b00, 11'(HOME_X), 10'(HOME_Y)}) begin
            n_err++;
            $display("FAIL reset_no_done: got done/mov=%b pos=(%0d,%0d) want 00 pos=(%0d,%0d)",
                     {done, moving}, display_pos_x, display_pos_y, HOME_X, HOME_Y);
        end
        mx = HOME_X;
        my = HOME_Y;
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) test_oob($urandom_range(40, 127), $urandom_range(0, 63));
                else                           test_oob($urandom_range(0, 127), $urandom_range(30, 63));
            end else begin
                test_move($urandom_range(0, 39), $urandom_range(0, 29),
                          $urandom_range(40, 100), $urandom_range(0, 3), 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_move(7, 7, 100, 0, 1'b0);
        test_move(9, 5, 100, 0, 1'b0);
        test_oob(40, 3);
        test_oob(3, 30);
        test_oob(127, 63);
`ifdef MOVER_SNAP_EN
        test_move(9, 5, 0, 0, 1'b0);
`endif
        test_move(0, 0, 100, 50, 1'b0);
        test_move(9, 5, 100, 0, 1'b1);
        test_move(9, 5, 100, 0, 1'b0);
        test_reset_mid_move(0, 0, 20);
        test_move(39, 29, 70, 2, 1'b1);
        test_move(0, 29, 60, 0, 1'b1);
        test_random(25);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
